// File: rtl/routing_table_manager_pkg.sv
// Shared types for the routing-state owner: node IDs, join FSM states,
// the registered routing table and the LFSR step used for random IDs.
package routing_table_manager_pkg;

  localparam int NODE_ID_W = 8;
  typedef logic [NODE_ID_W-1:0] node_id_t;

  localparam int       NUM_NODES    = 1 << NODE_ID_W;
  localparam node_id_t BROADCAST_ID = '1;

  // Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1 (maximal length)
  localparam node_id_t LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_PARENT,
    WAIT_JOIN_ACK,
    JOINED
  } join_state_t;

  typedef struct packed {
    logic                        parent_valid;
    node_id_t                    parent_node_id;
    logic                        this_node_valid;
    node_id_t                    this_node_id;
    logic [NUM_NODES-1:0]        valid;
    node_id_t [NUM_NODES-1:0]    entry;
  } routing_table_t;

  // One right-shifting Galois step; a non-zero state never reaches zero
  function automatic node_id_t lfsr_next(input node_id_t s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/routing_table_manager_lfsr.sv
// Free-running maximal-length Galois LFSR; exposes the raw state.
module node_id_lfsr
  import routing_table_manager_pkg::*;
#(
  parameter node_id_t SEED = node_id_t'(1)
) (
  input  logic     i_clk,
  input  logic     i_rst,
  output node_id_t o_state
);

  node_id_t r_state;

  // Advance every cycle; reset reloads the seed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= SEED;
    else       r_state <= lfsr_next(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/routing_table_manager.sv
// Owns parent/own-ID/routing-table state, runs the join handshake and,
// on the root, hands out child IDs.
module routing_table_manager
  import routing_table_manager_pkg::*;
#(
  parameter bit       IS_ROOT      = 1'b0,
  parameter int       RETRY_CYCLES = 1024,
  parameter node_id_t LFSR_SEED    = node_id_t'(1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_join_start,
  output logic           o_parent_request_valid,
  input  logic           i_parent_request_ready,
  input  logic           i_update_parent_valid,
  input  node_id_t       i_update_parent_node_id,
  input  logic           i_update_this_node_valid,
  input  node_id_t       i_update_this_node_id,
  input  logic           i_update_routing_table_valid,
  input  node_id_t       i_update_routing_table_key,
  input  node_id_t       i_update_routing_table_value,
  input  logic           i_update_routing_id_counter_valid,
  output routing_table_t o_routing_table,
  output node_id_t       o_temporal_id,
  output node_id_t       o_random_id,
  output node_id_t       o_routing_id_counter,
  output logic           o_is_root,
  output join_state_t    o_join_state,
  output logic           o_counter_exhausted
);

  localparam int                 TIMER_W      = $clog2(RETRY_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(RETRY_CYCLES - 1);

  routing_table_t     r_table;
  join_state_t        r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_req_valid;
  node_id_t           r_temporal_id;
  node_id_t           r_counter;
  logic               r_exhausted;
  node_id_t           w_lfsr;
  node_id_t           w_random_id;

  node_id_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_state (w_lfsr)
  );

  // Broadcast is never a usable node ID, so fold it onto its neighbour
  assign w_random_id = (w_lfsr == BROADCAST_ID) ? (BROADCAST_ID - node_id_t'(1)) : w_lfsr;

  // Join FSM and routing table; the explicit table write comes last so it
  // overrides the implicit parent entry when both hit the same key
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_table                 <= '0;
      r_table.this_node_valid <= IS_ROOT;
      r_state                 <= IS_ROOT ? JOINED : IDLE;
      r_timer                 <= '0;
      r_req_valid             <= 1'b0;
      r_temporal_id           <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_join_start) begin
            r_state       <= REQUEST;
            r_req_valid   <= 1'b1;
            r_temporal_id <= w_random_id;
          end
        end
        REQUEST: begin
          if (r_req_valid && i_parent_request_ready) begin
            r_state     <= WAIT_PARENT;
            r_req_valid <= 1'b0;
            r_timer     <= TIMER_RELOAD;
          end
        end
        WAIT_PARENT: begin
          if (i_update_parent_valid) begin
            r_table.parent_node_id                 <= i_update_parent_node_id;
            r_table.parent_valid                   <= 1'b1;
            r_table.entry[i_update_parent_node_id] <= i_update_parent_node_id;
            r_table.valid[i_update_parent_node_id] <= 1'b1;
            r_state                                <= WAIT_JOIN_ACK;
            r_timer                                <= TIMER_RELOAD;
          end else if (r_timer == '0) begin
            r_state     <= REQUEST;
            r_req_valid <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        WAIT_JOIN_ACK: begin
          if (i_update_this_node_valid) begin
            r_table.this_node_id    <= i_update_this_node_id;
            r_table.this_node_valid <= 1'b1;
            r_state                 <= JOINED;
          end else if (r_timer == '0) begin
            r_table.parent_valid <= 1'b0;
            r_state              <= REQUEST;
            r_req_valid          <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        JOINED: ;
        default: r_state <= IDLE;
      endcase

      if (i_update_routing_table_valid && (i_update_routing_table_key != BROADCAST_ID)) begin
        r_table.entry[i_update_routing_table_key] <= i_update_routing_table_value;
        r_table.valid[i_update_routing_table_key] <= 1'b1;
      end
    end
  end

  // Root child-ID allocator; saturates one below broadcast and flags exhaustion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_counter   <= IS_ROOT ? node_id_t'(1) : node_id_t'(0);
      r_exhausted <= 1'b0;
    end else if (IS_ROOT && i_update_routing_id_counter_valid) begin
      if (r_counter == (BROADCAST_ID - node_id_t'(1))) r_exhausted <= 1'b1;
      else                                              r_counter   <= r_counter + node_id_t'(1);
    end
  end

  assign o_parent_request_valid = r_req_valid;
  assign o_routing_table        = r_table;
  assign o_temporal_id          = r_temporal_id;
  assign o_random_id            = w_random_id;
  assign o_routing_id_counter   = r_counter;
  assign o_is_root              = IS_ROOT;
  assign o_join_state           = r_state;
  assign o_counter_exhausted    = r_exhausted;

endmodule

// File: tb/tb_routing_table_manager.sv
// Bench for routing_table_manager: a non-root node and a root node side by side,
// checked against a table/ID model kept here.
module tb_routing_table_manager;
  import routing_table_manager_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic join_start = 1'b0, req_ready = 1'b0;
  logic par_valid = 1'b0, this_valid = 1'b0, rt_valid = 1'b0, ctr_valid = 1'b0;
  node_id_t par_id = '0, this_id = '0, rt_key = '0, rt_value = '0;

  logic           n_req_valid, n_is_root, n_exhausted;
  routing_table_t n_table;
  node_id_t       n_temporal, n_random, n_counter;
  join_state_t    n_state;

  logic           root_req_valid, root_is_root, root_exhausted;
  routing_table_t root_table;
  node_id_t       root_temporal, root_random, root_counter;
  join_state_t    root_state;

  int n_vec = 0;
  int n_err = 0;

  bit       exp_valid [NUM_NODES];
  node_id_t exp_entry [NUM_NODES];
  bit       exp_pvalid;
  node_id_t exp_parent;

  always #5 clk = ~clk;

  routing_table_manager #(.IS_ROOT(1'b0), .RETRY_CYCLES(16), .LFSR_SEED(8'h01)) dut (
    .i_clk(clk), .i_rst(rst), .i_join_start(join_start),
    .o_parent_request_valid(n_req_valid), .i_parent_request_ready(req_ready),
    .i_update_parent_valid(par_valid), .i_update_parent_node_id(par_id),
    .i_update_this_node_valid(this_valid), .i_update_this_node_id(this_id),
    .i_update_routing_table_valid(rt_valid), .i_update_routing_table_key(rt_key),
    .i_update_routing_table_value(rt_value),
    .i_update_routing_id_counter_valid(ctr_valid),
    .o_routing_table(n_table), .o_temporal_id(n_temporal), .o_random_id(n_random),
    .o_routing_id_counter(n_counter), .o_is_root(n_is_root), .o_join_state(n_state),
    .o_counter_exhausted(n_exhausted)
  );

  routing_table_manager #(.IS_ROOT(1'b1), .RETRY_CYCLES(16), .LFSR_SEED(8'h01)) dut_root (
    .i_clk(clk), .i_rst(rst), .i_join_start(1'b0),
    .o_parent_request_valid(root_req_valid), .i_parent_request_ready(1'b0),
    .i_update_parent_valid(1'b0), .i_update_parent_node_id(8'h00),
    .i_update_this_node_valid(1'b0), .i_update_this_node_id(8'h00),
    .i_update_routing_table_valid(1'b0), .i_update_routing_table_key(8'h00),
    .i_update_routing_table_value(8'h00),
    .i_update_routing_id_counter_valid(ctr_valid),
    .o_routing_table(root_table), .o_temporal_id(root_temporal), .o_random_id(root_random),
    .o_routing_id_counter(root_counter), .o_is_root(root_is_root), .o_join_state(root_state),
    .o_counter_exhausted(root_exhausted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_NODES; i++) begin
      exp_valid[i] = 1'b0;
      exp_entry[i] = '0;
    end
    exp_pvalid = 1'b0;
    exp_parent = '0;
  endtask

  task automatic model_write(input node_id_t k, input node_id_t v);
    if (k != 8'hFF) begin
      exp_valid[k] = 1'b1;
      exp_entry[k] = v;
    end
  endtask

  task automatic model_parent(input node_id_t p);
    exp_pvalid = 1'b1;
    exp_parent = p;
    exp_valid[p] = 1'b1;
    exp_entry[p] = p;
  endtask

  task automatic tbl_write(input node_id_t k, input node_id_t v);
    rt_valid = 1'b1; rt_key = k; rt_value = v;
    model_write(k, v);
    tick();
    rt_valid = 1'b0;
    $display("table write key=%02h value=%02h", k, v);
  endtask

  task automatic compare_table();
    check("parent_valid", n_table.parent_valid, exp_pvalid);
    if (exp_pvalid) check("parent_id", n_table.parent_node_id, exp_parent);
    for (int i = 0; i < NUM_NODES; i++) begin
      check($sformatf("valid[%02h]", i), n_table.valid[i], exp_valid[i]);
      if (exp_valid[i]) check($sformatf("entry[%02h]", i), n_table.entry[i], exp_entry[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bit       seen [NUM_NODES];
    int       bad, distinct, cnt, n1;
    node_id_t rd, tmp, v, p, k;

    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset values, both flavours
    check("rst_state", n_state, IDLE);
    check("rst_req_valid", n_req_valid, 1'b0);
    check("rst_temporal", n_temporal, 8'h00);
    check("rst_this_valid", n_table.this_node_valid, 1'b0);
    check("rst_counter", n_counter, 8'h00);
    check("rst_exhausted", n_exhausted, 1'b0);
    check("rst_is_root", n_is_root, 1'b0);
    compare_table();
    check("root_rst_state", root_state, JOINED);
    check("root_rst_this_valid", root_table.this_node_valid, 1'b1);
    check("root_rst_this_id", root_table.this_node_id, 8'h00);
    check("root_rst_counter", root_counter, 8'h01);
    check("root_rst_is_root", root_is_root, 1'b1);
    check("root_rst_exhausted", root_exhausted, 1'b0);
    $display("reset checked");

    // Random ID range and coverage over one LFSR period
    bad = 0; distinct = 0;
    for (int i = 0; i < NUM_NODES; i++) seen[i] = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (n_random == 8'h00 || n_random == 8'hFF) bad++;
      if (c < 255 && !seen[n_random]) begin
        seen[n_random] = 1'b1;
        distinct++;
      end
      tick();
    end
    check("lfsr_range", bad, 0);
    check("lfsr_distinct", distinct, 254);
    $display("lfsr: %0d distinct ids in one period", distinct);

    // Non-root join with parent 03 / id 07
    rd = n_random;
    join_start = 1'b1; req_ready = 1'b1;
    tick();
    join_start = 1'b0;
    check("join_state_req", n_state, REQUEST);
    check("join_req_valid", n_req_valid, 1'b1);
    check("join_temporal", n_temporal, rd);
    tick();
    req_ready = 1'b0;
    check("join_state_wp", n_state, WAIT_PARENT);
    check("join_req_drop", n_req_valid, 1'b0);
    v = 8'($urandom_range(16, 250));
    par_valid = 1'b1; par_id = 8'h03; this_valid = 1'b1; this_id = 8'h55;
    rt_valid = 1'b1; rt_key = 8'h03; rt_value = v;
    model_parent(8'h03);
    model_write(8'h03, v);
    tick();
    par_valid = 1'b0; this_valid = 1'b0; rt_valid = 1'b0;
    $display("join: parent 03 with explicit entry[03]=%02h", v);
    check("join_state_wja", n_state, WAIT_JOIN_ACK);
    check("join_this_dropped", n_table.this_node_valid, 1'b0);
    compare_table();
    this_valid = 1'b1; this_id = 8'h07;
    tick();
    this_valid = 1'b0;
    check("join_state_joined", n_state, JOINED);
    check("join_this_valid", n_table.this_node_valid, 1'b1);
    check("join_this_id", n_table.this_node_id, 8'h07);
    join_start = 1'b1; par_valid = 1'b1; par_id = 8'h44; this_valid = 1'b1; this_id = 8'h66;
    tick();
    join_start = 1'b0; par_valid = 1'b0; this_valid = 1'b0;
    check("joined_sticky", n_state, JOINED);
    check("joined_parent", n_table.parent_node_id, 8'h03);
    check("joined_this_id", n_table.this_node_id, 8'h07);
    check("joined_req_valid", n_req_valid, 1'b0);

    // Table writes, broadcast key dropped
    tbl_write(8'h10, 8'h03);
    tbl_write(8'hFF, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 20; i++) begin
      k = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      tbl_write(k, 8'($urandom_range(0, 255)));
    end
    compare_table();

    // Parent-request timeout and retry
    do_reset();
    join_start = 1'b1; req_ready = 1'b0;
    tick();
    join_start = 1'b0;
    repeat (3) tick();
    check("req_hold_valid", n_req_valid, 1'b1);
    check("req_hold_state", n_state, REQUEST);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tmp = n_temporal;
    check("to_state_wp", n_state, WAIT_PARENT);
    cnt = 0;
    while (n_req_valid == 1'b0 && cnt < 100) begin
      tick();
      cnt++;
    end
    $display("parent timeout after %0d cycles", cnt);
    check("to_cycles", cnt, 16);
    check("to_state_req", n_state, REQUEST);
    check("to_temporal_same", n_temporal, tmp);

    // Async reset in WAIT_PARENT clears the table immediately
    k = 8'($urandom_range(0, 254));
    tbl_write(k, 8'($urandom_range(0, 255)));
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("mid_state_wp", n_state, WAIT_PARENT);
    compare_table();
    rst = 1'b1;
    #1;
    model_reset();
    $display("async reset in WAIT_PARENT");
    check("mid_rst_state", n_state, IDLE);
    check("mid_rst_req", n_req_valid, 1'b0);
    compare_table();
    tick();
    rst = 1'b0;
    tick();

    // Async reset during a pending handshake
    join_start = 1'b1;
    tick();
    join_start = 1'b0;
    check("pend_req_valid", n_req_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("pend_rst_req", n_req_valid, 1'b0);
    check("pend_rst_state", n_state, IDLE);
    tick();
    rst = 1'b0;
    tick();

    // Join-ack timeout keeps the parent entry
    p = 8'($urandom_range(1, 254));
    join_start = 1'b1; req_ready = 1'b1;
    tick();
    join_start = 1'b0;
    tick();
    req_ready = 1'b0;
    par_valid = 1'b1; par_id = p;
    model_parent(p);
    tick();
    par_valid = 1'b0;
    check("ack_state_wja", n_state, WAIT_JOIN_ACK);
    cnt = 0;
    while (n_state == WAIT_JOIN_ACK && cnt < 100) begin
      tick();
      cnt++;
    end
    exp_pvalid = 1'b0;
    $display("join-ack timeout after %0d cycles, parent %02h", cnt, p);
    check("ack_cycles", cnt, 16);
    check("ack_state_req", n_state, REQUEST);
    check("ack_req_valid", n_req_valid, 1'b1);
    compare_table();

    // Root child-ID counter and saturation; non-root ignores the strobe
    n1 = $urandom_range(10, 200);
    ctr_valid = 1'b1;
    repeat (n1) tick();
    check("ctr_partial", root_counter, 1 + n1);
    repeat (253 - n1) tick();
    check("ctr_fe", root_counter, 8'hFE);
    check("ctr_not_exh", root_exhausted, 1'b0);
    tick();
    check("ctr_sat", root_counter, 8'hFE);
    check("ctr_exh", root_exhausted, 1'b1);
    tick();
    ctr_valid = 1'b0;
    check("ctr_hold", root_counter, 8'hFE);
    check("ctr_exh_sticky", root_exhausted, 1'b1);
    check("nonroot_ctr", n_counter, 8'h00);
    check("nonroot_exh", n_exhausted, 1'b0);
    $display("root counter saturated");
    do_reset();
    check("root_rerst_counter", root_counter, 8'h01);
    check("root_rerst_exh", root_exhausted, 1'b0);
    check("root_rerst_state", root_state, JOINED);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
